// File: rtl/riscv_test_monitor.sv
// Passive end-of-test monitor on the core data bus: tohost pass/fail decode, verify word, watchdog, counters.
// Optional store signature enabled by defining RISCV_MON_SIG_EN (sig_o tied to zero otherwise).
module riscv_test_monitor #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0100,
  parameter logic [31:0] VERIFY_ADDR    = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [31:0] code_o,
  output logic [31:0] verify_o,
  output logic [31:0] store_cnt_o,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] sig_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t next_state;

  logic st;
  logic run;
  logic hit_tohost;
  logic hit_verify;
  logic next_terminal;

  assign st         = data_ce_i & data_we_i;
  assign run        = (state == RUN);
  assign hit_tohost = st && (data_addr_i == TOHOST_ADDR);
  assign hit_verify = st && (data_addr_i == VERIFY_ADDR);

  // A tohost store on the watchdog's last cycle takes priority over the timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: next_state = RUN;
      RUN: begin
        if (hit_tohost) begin
          next_state = (data_i == 32'd1) ? PASS : FAIL;
        end else if (cycle_cnt_o == TIMEOUT_LAST) begin
          next_state = TIMEOUT;
        end
      end
      PASS:    next_state = PASS;
      FAIL:    next_state = FAIL;
      TIMEOUT: next_state = TIMEOUT;
      default: next_state = IDLE;
    endcase
  end

  assign next_terminal = (next_state == PASS) || (next_state == FAIL) ||
                         (next_state == TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= next_state;
      done_o    <= next_terminal;
      pass_o    <= (next_state == PASS);
      timeout_o <= (next_state == TIMEOUT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_o      <= '0;
      verify_o    <= '0;
      store_cnt_o <= '0;
      cycle_cnt_o <= '0;
    end else if (run) begin
      cycle_cnt_o <= cycle_cnt_o + 32'd1;
      if (st) begin
        store_cnt_o <= store_cnt_o + 32'd1;
      end
      if (hit_verify) begin
        verify_o <= data_i;
      end
      if (hit_tohost) begin
        code_o <= data_i;
      end
    end
  end

`ifdef RISCV_MON_SIG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_o <= '0;
    end else if (run && st) begin
      sig_o <= {sig_o[30:0], sig_o[31]} ^ data_addr_i ^ data_i;
    end
  end
`else
  assign sig_o = 32'h0;
`endif

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed self-checking bench for riscv_test_monitor (TIMEOUT_CYCLES overridden to 20).
module tb_riscv_test_monitor;

  logic        clk;
  logic        rst;
  logic        data_ce_i;
  logic        data_we_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_i;
  logic        done_o;
  logic        pass_o;
  logic        timeout_o;
  logic [31:0] code_o;
  logic [31:0] verify_o;
  logic [31:0] store_cnt_o;
  logic [31:0] cycle_cnt_o;
  logic [31:0] sig_o;

  int checks   = 0;
  int failures = 0;

  riscv_test_monitor #(
    .TOHOST_ADDR   (32'h0000_0100),
    .VERIFY_ADDR   (32'h0000_0000),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_ce_i  (data_ce_i),
    .data_we_i  (data_we_i),
    .data_addr_i(data_addr_i),
    .data_i     (data_i),
    .done_o     (done_o),
    .pass_o     (pass_o),
    .timeout_o  (timeout_o),
    .code_o     (code_o),
    .verify_o   (verify_o),
    .store_cnt_o(store_cnt_o),
    .cycle_cnt_o(cycle_cnt_o),
    .sig_o      (sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one bus cycle just after an edge, then sample 1 time unit after the next edge.
  task automatic cyc(input logic ce, input logic we, input logic [31:0] addr, input logic [31:0] dat);
    data_ce_i   = ce;
    data_we_i   = we;
    data_addr_i = addr;
    data_i      = dat;
    @(posedge clk);
    #1;
    data_ce_i   = 1'b0;
    data_we_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".done"},    {31'h0, done_o},    32'h0);
    chk({tag, ".pass"},    {31'h0, pass_o},    32'h0);
    chk({tag, ".timeout"}, {31'h0, timeout_o}, 32'h0);
    chk({tag, ".code"},    code_o,             32'h0);
    chk({tag, ".verify"},  verify_o,           32'h0);
    chk({tag, ".stores"},  store_cnt_o,        32'h0);
    chk({tag, ".cycles"},  cycle_cnt_o,        32'h0);
    chk({tag, ".sig"},     sig_o,              32'h0);
  endtask

  // Reset, release just after an edge, then take the IDLE->RUN edge (store there is ignored).
  task automatic restart();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF);
  endtask

  initial begin
    rst         = 1'b1;
    data_ce_i   = 1'b0;
    data_we_i   = 1'b0;
    data_addr_i = 32'h0;
    data_i      = 32'h0;
    #2;
    chk_zero("reset_async");
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");

    // Test 1: verify word then passing tohost store
    rst = 1'b0;
    cyc(1'b1, 1'b1, 32'h0, 32'h0000_0033);
    chk("t1.enter_verify", verify_o, 32'h0);
    chk("t1.enter_stores", store_cnt_o, 32'h0);
    chk("t1.enter_cycles", cycle_cnt_o, 32'h0);
    cyc(1'b1, 1'b1, 32'h0, 32'd5);
    chk("t1.verify", verify_o, 32'd5);
    chk("t1.stores1", store_cnt_o, 32'd1);
    chk("t1.cycles1", cycle_cnt_o, 32'd1);
    chk("t1.done0", {31'h0, done_o}, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0100, 32'd1);
    chk("t1.done", {31'h0, done_o}, 32'h1);
    chk("t1.pass", {31'h0, pass_o}, 32'h1);
    chk("t1.timeout", {31'h0, timeout_o}, 32'h0);
    chk("t1.code", code_o, 32'd1);
    chk("t1.stores", store_cnt_o, 32'd2);
    chk("t1.cycles", cycle_cnt_o, 32'd2);
    cyc(1'b1, 1'b1, 32'h0, 32'd9);
    chk("t1.frozen_verify", verify_o, 32'd5);
    chk("t1.frozen_stores", store_cnt_o, 32'd2);
    chk("t1.frozen_cycles", cycle_cnt_o, 32'd2);

    // Tests 2 and 4: ignored bus cycles, near-miss address, failing tohost store
    restart();
    cyc(1'b1, 1'b0, 32'h0000_0100, 32'd1);
    chk("t4.read_done", {31'h0, done_o}, 32'h0);
    chk("t4.read_stores", store_cnt_o, 32'h0);
    cyc(1'b0, 1'b1, 32'h0000_0100, 32'd1);
    chk("t4.noce_done", {31'h0, done_o}, 32'h0);
    chk("t4.noce_stores", store_cnt_o, 32'h0);
    cyc(1'b1, 1'b1, 32'h0000_0104, 32'd1);
    chk("t2.nearmiss_done", {31'h0, done_o}, 32'h0);
    chk("t2.nearmiss_stores", store_cnt_o, 32'd1);
    cyc(1'b1, 1'b1, 32'h0000_0100, 32'd7);
    chk("t2.done", {31'h0, done_o}, 32'h1);
    chk("t2.pass", {31'h0, pass_o}, 32'h0);
    chk("t2.timeout", {31'h0, timeout_o}, 32'h0);
    chk("t2.code", code_o, 32'd7);
    chk("t2.stores", store_cnt_o, 32'd2);
    chk("t2.cycles", cycle_cnt_o, 32'd4);
    cyc(1'b1, 1'b1, 32'h0000_0100, 32'd1);
    cyc(1'b1, 1'b0, 32'h0000_0100, 32'd1);
    chk("t2.after_pass", {31'h0, pass_o}, 32'h0);
    chk("t2.after_code", code_o, 32'd7);
    chk("t2.after_stores", store_cnt_o, 32'd2);
    chk("t2.after_cycles", cycle_cnt_o, 32'd4);

    // Test 3: watchdog after 20 RUN edges
    restart();
    idle(19);
    chk("t3.pre_done", {31'h0, done_o}, 32'h0);
    chk("t3.pre_cycles", cycle_cnt_o, 32'd19);
    idle(1);
    chk("t3.timeout", {31'h0, timeout_o}, 32'h1);
    chk("t3.done", {31'h0, done_o}, 32'h1);
    chk("t3.pass", {31'h0, pass_o}, 32'h0);
    chk("t3.cycles", cycle_cnt_o, 32'd20);
    idle(2);
    chk("t3.frozen_cycles", cycle_cnt_o, 32'd20);

    // Test 3b: tohost store on the expiry edge wins
    restart();
    idle(19);
    cyc(1'b1, 1'b1, 32'h0000_0100, 32'd1);
    chk("t3b.pass", {31'h0, pass_o}, 32'h1);
    chk("t3b.timeout", {31'h0, timeout_o}, 32'h0);
    chk("t3b.cycles", cycle_cnt_o, 32'd20);
    chk("t3b.stores", store_cnt_o, 32'd1);

    // Test 5: asynchronous reset between edges, then restart from zero
    restart();
    cyc(1'b1, 1'b1, 32'h0, 32'h55);
    idle(2);
    chk("t5.pre_verify", verify_o, 32'h55);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("t5.async");
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("t5.enter_cycles", cycle_cnt_o, 32'd0);
    idle(1);
    chk("t5.restart_cycles", cycle_cnt_o, 32'd1);
    chk("t5.restart_stores", store_cnt_o, 32'd0);

    // Test 6: signature (rotate-left, xor address and data)
    restart();
    cyc(1'b1, 1'b1, 32'h0000_0004, 32'h0000_000A);
    cyc(1'b1, 1'b1, 32'h0000_0100, 32'h0000_0001);
`ifdef RISCV_MON_SIG_EN
    chk("t6.sig", sig_o, 32'h0000_011D);
`else
    chk("t6.sig", sig_o, 32'h0);
`endif
    chk("t6.pass", {31'h0, pass_o}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
